// File: rtl/axi4_master_core_if.sv
// ============================================================================
// Module  : axi4_master_core_if
// Brief   : AXI4 bus bundle (AW, W, B, AR, R) between the initiator engine
//           and the attached slave side.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi4_master_core_if;
  // write address channel
  logic [63:0] awaddr;
  logic [31:0] awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [3:0]  awqos;
  logic [3:0]  awregion;
  logic        awvalid;
  logic        awready;
  // write data channel
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // write response channel
  logic [31:0] bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  // read address channel
  logic [63:0] araddr;
  logic [31:0] arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [3:0]  arregion;
  logic        arvalid;
  logic        arready;
  // read data channel
  logic [15:0] rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot,
           awqos, awregion, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output araddr, arid, arlen, arsize, arburst, arcache, arprot, arregion,
           arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot,
           awqos, awregion, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  araddr, arid, arlen, arsize, arburst, arcache, arprot, arregion,
           arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

`default_nettype wire

// File: rtl/axi4_master_core.sv
// ============================================================================
// Module  : axi4_master_core
// Brief   : Command-driven AXI4 initiator engine. Single AR/AW/W commands are
//           staged, driven onto registered bus channels, and completions,
//           write responses, read beats and reset release are reported as
//           one-cycle event pulses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
// One request channel: staging register set feeding a bus register set.
// Only one request may be outstanding, so a new command is refused while
// either the staging slot or the bus VALID is occupied.
// ----------------------------------------------------------------------------
module axi4_master_core_chan #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_fields,
  output logic [WIDTH-1:0] bus_fields,
  output logic             bus_valid,
  input  logic             bus_ready,
  output logic             ack
);
  logic             staged_valid;
  logic [WIDTH-1:0] staged_fields;
  logic             accept;
  logic             handshake;

  assign cmd_ready = !staged_valid && !bus_valid;
  assign accept    = cmd_valid && cmd_ready;
  assign handshake = bus_valid && bus_ready;

  // Staging slot: loaded on command accept, released by the bus handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      staged_valid  <= 1'b0;
      staged_fields <= '0;
    end else begin
      if (accept) begin
        staged_fields <= cmd_fields;
        staged_valid  <= 1'b1;
      end else if (handshake) begin
        staged_valid <= 1'b0;
      end
    end
  end

  // Bus registers mirror staging; a handshake forces VALID low at that edge
  // so the request is never presented twice.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_fields <= '0;
      bus_valid  <= 1'b0;
      ack        <= 1'b0;
    end else begin
      bus_fields <= staged_fields;
      bus_valid  <= staged_valid && !handshake;
      ack        <= handshake;
    end
  end
endmodule

// ----------------------------------------------------------------------------
// Top level engine.
// ----------------------------------------------------------------------------
module axi4_master_core #(
  parameter int ID_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [31:0]          id_width,
  // AR command side
  input  logic                 ar_cmd_valid,
  output logic                 ar_cmd_ready,
  input  logic [63:0]          ar_cmd_addr,
  input  logic [31:0]          ar_cmd_id,
  input  logic [7:0]           ar_cmd_len,
  input  logic [2:0]           ar_cmd_size,
  input  logic [1:0]           ar_cmd_burst,
  input  logic [3:0]           ar_cmd_cache,
  input  logic [2:0]           ar_cmd_prot,
  input  logic [3:0]           ar_cmd_region,
  // AW command side
  input  logic                 aw_cmd_valid,
  output logic                 aw_cmd_ready,
  input  logic [63:0]          aw_cmd_addr,
  input  logic [31:0]          aw_cmd_id,
  input  logic [7:0]           aw_cmd_len,
  input  logic [2:0]           aw_cmd_size,
  input  logic [1:0]           aw_cmd_burst,
  input  logic [3:0]           aw_cmd_cache,
  input  logic [2:0]           aw_cmd_prot,
  input  logic [3:0]           aw_cmd_region,
  // W command side
  input  logic                 w_cmd_valid,
  output logic                 w_cmd_ready,
  input  logic [63:0]          w_cmd_data,
  input  logic [7:0]           w_cmd_strb,
  input  logic                 w_cmd_last,
  // AXI4 bus
  axi4_master_core_if.master   bus,
  // event pulses
  output logic                 awreq_ack,
  output logic                 arreq_ack,
  output logic                 wdata_ack,
  output logic                 bresp_valid,
  output logic [31:0]          bresp_id,
  output logic [1:0]           bresp_resp,
  output logic                 rresp_valid,
  output logic [15:0]          rresp_id,
  output logic [63:0]          rresp_data,
  output logic [1:0]           rresp_resp,
  output logic                 rresp_last,
  output logic                 reset_ev
);
  localparam int ADDR_CMD_W = 120;
  localparam int DATA_CMD_W = 73;

  logic [ADDR_CMD_W-1:0] aw_bus_fields;
  logic [ADDR_CMD_W-1:0] ar_bus_fields;
  logic [DATA_CMD_W-1:0] w_bus_fields;
  logic                  aw_bus_valid;
  logic                  ar_bus_valid;
  logic                  w_bus_valid;
  logic                  b_fire;
  logic                  r_fire;
  logic                  in_reset;

  assign id_width = 32'(ID_WIDTH);

  axi4_master_core_chan #(.WIDTH(ADDR_CMD_W)) u_aw_chan (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (aw_cmd_valid),
    .cmd_ready  (aw_cmd_ready),
    .cmd_fields ({aw_cmd_addr, aw_cmd_id, aw_cmd_len, aw_cmd_size,
                  aw_cmd_burst, aw_cmd_cache, aw_cmd_prot, aw_cmd_region}),
    .bus_fields (aw_bus_fields),
    .bus_valid  (aw_bus_valid),
    .bus_ready  (bus.awready),
    .ack        (awreq_ack)
  );

  axi4_master_core_chan #(.WIDTH(DATA_CMD_W)) u_w_chan (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (w_cmd_valid),
    .cmd_ready  (w_cmd_ready),
    .cmd_fields ({w_cmd_data, w_cmd_strb, w_cmd_last}),
    .bus_fields (w_bus_fields),
    .bus_valid  (w_bus_valid),
    .bus_ready  (bus.wready),
    .ack        (wdata_ack)
  );

  axi4_master_core_chan #(.WIDTH(ADDR_CMD_W)) u_ar_chan (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (ar_cmd_valid),
    .cmd_ready  (ar_cmd_ready),
    .cmd_fields ({ar_cmd_addr, ar_cmd_id, ar_cmd_len, ar_cmd_size,
                  ar_cmd_burst, ar_cmd_cache, ar_cmd_prot, ar_cmd_region}),
    .bus_fields (ar_bus_fields),
    .bus_valid  (ar_bus_valid),
    .bus_ready  (bus.arready),
    .ack        (arreq_ack)
  );

  assign {bus.awaddr, bus.awid, bus.awlen, bus.awsize, bus.awburst,
          bus.awcache, bus.awprot, bus.awregion} = aw_bus_fields;
  assign bus.awvalid = aw_bus_valid;
  assign bus.awlock  = 1'b0;
  assign bus.awqos   = 4'd0;

  assign {bus.wdata, bus.wstrb, bus.wlast} = w_bus_fields;
  assign bus.wvalid = w_bus_valid;

  assign {bus.araddr, bus.arid, bus.arlen, bus.arsize, bus.arburst,
          bus.arcache, bus.arprot, bus.arregion} = ar_bus_fields;
  assign bus.arvalid = ar_bus_valid;

  // The engine always sinks responses, so the response readies are tied high.
  assign bus.bready = 1'b1;
  assign bus.rready = 1'b1;

  assign b_fire = bus.bvalid && bus.bready;
  assign r_fire = bus.rvalid && bus.rready;

  // Report each write response beat one cycle after it is sampled.
  always_ff @(posedge clock) begin
    if (reset) begin
      bresp_valid <= 1'b0;
      bresp_id    <= '0;
      bresp_resp  <= '0;
    end else begin
      bresp_valid <= b_fire;
      if (b_fire) begin
        bresp_id   <= bus.bid;
        bresp_resp <= bus.bresp;
      end
    end
  end

  // Report each read data beat one cycle after it is sampled.
  always_ff @(posedge clock) begin
    if (reset) begin
      rresp_valid <= 1'b0;
      rresp_id    <= '0;
      rresp_data  <= '0;
      rresp_resp  <= '0;
      rresp_last  <= 1'b0;
    end else begin
      rresp_valid <= r_fire;
      if (r_fire) begin
        rresp_id   <= bus.rid;
        rresp_data <= bus.rdata;
        rresp_resp <= bus.rresp;
        rresp_last <= bus.rlast;
      end
    end
  end

  // Pulse reset_ev on the first edge after reset is released.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_reset <= 1'b1;
      reset_ev <= 1'b0;
    end else begin
      reset_ev <= in_reset;
      in_reset <= 1'b0;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_axi4_master_core.sv
// ============================================================================
// Module  : tb_axi4_master_core
// Brief   : Scoreboard bench for axi4_master_core. Stimulus pushes expected
//           transactions into queues; a negedge monitor compares bus and
//           event outputs against a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi4_master_core;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [31:0]  id_width;
  logic         aw_cmd_valid = 1'b0, ar_cmd_valid = 1'b0, w_cmd_valid = 1'b0;
  logic         aw_cmd_ready, ar_cmd_ready, w_cmd_ready;
  logic [119:0] aw_cmd_vec = '0, ar_cmd_vec = '0;
  logic [72:0]  w_cmd_vec = '0;
  logic [63:0]  aw_cmd_addr, ar_cmd_addr, w_cmd_data;
  logic [31:0]  aw_cmd_id, ar_cmd_id;
  logic [7:0]   aw_cmd_len, ar_cmd_len, w_cmd_strb;
  logic [2:0]   aw_cmd_size, ar_cmd_size, aw_cmd_prot, ar_cmd_prot;
  logic [1:0]   aw_cmd_burst, ar_cmd_burst;
  logic [3:0]   aw_cmd_cache, ar_cmd_cache, aw_cmd_region, ar_cmd_region;
  logic         w_cmd_last;
  logic         awreq_ack, arreq_ack, wdata_ack;
  logic         bresp_valid, rresp_valid, rresp_last, reset_ev;
  logic [31:0]  bresp_id;
  logic [1:0]   bresp_resp, rresp_resp;
  logic [15:0]  rresp_id;
  logic [63:0]  rresp_data;

  assign {aw_cmd_addr, aw_cmd_id, aw_cmd_len, aw_cmd_size, aw_cmd_burst,
          aw_cmd_cache, aw_cmd_prot, aw_cmd_region} = aw_cmd_vec;
  assign {ar_cmd_addr, ar_cmd_id, ar_cmd_len, ar_cmd_size, ar_cmd_burst,
          ar_cmd_cache, ar_cmd_prot, ar_cmd_region} = ar_cmd_vec;
  assign {w_cmd_data, w_cmd_strb, w_cmd_last} = w_cmd_vec;

  // slave-side drive
  logic        awready_d = 1'b0, wready_d = 1'b0, arready_d = 1'b0;
  logic        bvalid_d = 1'b0, rvalid_d = 1'b0, rlast_d = 1'b0;
  logic [31:0] bid_d = '0;
  logic [1:0]  bresp_d = '0, rresp_d = '0;
  logic [15:0] rid_d = '0;
  logic [63:0] rdata_d = '0;

  axi4_master_core_if bus();
  assign bus.awready = awready_d;
  assign bus.wready  = wready_d;
  assign bus.arready = arready_d;
  assign bus.bvalid  = bvalid_d;
  assign bus.bid     = bid_d;
  assign bus.bresp   = bresp_d;
  assign bus.rvalid  = rvalid_d;
  assign bus.rid     = rid_d;
  assign bus.rdata   = rdata_d;
  assign bus.rresp   = rresp_d;
  assign bus.rlast   = rlast_d;

  axi4_master_core #(.ID_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .id_width(id_width),
    .ar_cmd_valid(ar_cmd_valid), .ar_cmd_ready(ar_cmd_ready),
    .ar_cmd_addr(ar_cmd_addr), .ar_cmd_id(ar_cmd_id), .ar_cmd_len(ar_cmd_len),
    .ar_cmd_size(ar_cmd_size), .ar_cmd_burst(ar_cmd_burst),
    .ar_cmd_cache(ar_cmd_cache), .ar_cmd_prot(ar_cmd_prot),
    .ar_cmd_region(ar_cmd_region),
    .aw_cmd_valid(aw_cmd_valid), .aw_cmd_ready(aw_cmd_ready),
    .aw_cmd_addr(aw_cmd_addr), .aw_cmd_id(aw_cmd_id), .aw_cmd_len(aw_cmd_len),
    .aw_cmd_size(aw_cmd_size), .aw_cmd_burst(aw_cmd_burst),
    .aw_cmd_cache(aw_cmd_cache), .aw_cmd_prot(aw_cmd_prot),
    .aw_cmd_region(aw_cmd_region),
    .w_cmd_valid(w_cmd_valid), .w_cmd_ready(w_cmd_ready),
    .w_cmd_data(w_cmd_data), .w_cmd_strb(w_cmd_strb), .w_cmd_last(w_cmd_last),
    .bus(bus.master),
    .awreq_ack(awreq_ack), .arreq_ack(arreq_ack), .wdata_ack(wdata_ack),
    .bresp_valid(bresp_valid), .bresp_id(bresp_id), .bresp_resp(bresp_resp),
    .rresp_valid(rresp_valid), .rresp_id(rresp_id), .rresp_data(rresp_data),
    .rresp_resp(rresp_resp), .rresp_last(rresp_last), .reset_ev(reset_ev)
  );

  // channel views: 0 = AW, 1 = W, 2 = AR
  logic [2:0]   cv, cr, bv, br, ak;
  logic [119:0] bf [3];
  assign cv = {ar_cmd_valid, w_cmd_valid, aw_cmd_valid};
  assign cr = {ar_cmd_ready, w_cmd_ready, aw_cmd_ready};
  assign bv = {bus.arvalid, bus.wvalid, bus.awvalid};
  assign br = {arready_d, wready_d, awready_d};
  assign ak = {arreq_ack, wdata_ack, awreq_ack};
  assign bf[0] = {bus.awaddr, bus.awid, bus.awlen, bus.awsize, bus.awburst,
                  bus.awcache, bus.awprot, bus.awregion};
  assign bf[1] = {47'd0, bus.wdata, bus.wstrb, bus.wlast};
  assign bf[2] = {bus.araddr, bus.arid, bus.arlen, bus.arsize, bus.arburst,
                  bus.arcache, bus.arprot, bus.arregion};

  string chn [3] = '{"aw", "w", "ar"};

  int n_vec = 0;
  int n_err = 0;

  logic [119:0] q_aw [$];
  logic [119:0] q_w  [$];
  logic [119:0] q_ar [$];
  logic [33:0]  q_b  [$];
  logic [82:0]  q_r  [$];

  int rmode [3] = '{0, 0, 0};  // 0 random, 1 always ready, 2 never ready

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int q_size(input int ch);
    case (ch)
      0:       return q_aw.size();
      1:       return q_w.size();
      default: return q_ar.size();
    endcase
  endfunction

  function automatic logic [119:0] q_front(input int ch);
    case (ch)
      0:       return q_aw[0];
      1:       return q_w[0];
      default: return q_ar[0];
    endcase
  endfunction

  function automatic void q_push(input int ch, input logic [119:0] v);
    case (ch)
      0:       q_aw.push_back(v);
      1:       q_w.push_back(v);
      default: q_ar.push_back(v);
    endcase
  endfunction

  function automatic void q_pop(input int ch);
    case (ch)
      0:       void'(q_aw.pop_front());
      1:       void'(q_w.pop_front());
      default: void'(q_ar.pop_front());
    endcase
  endfunction

  function automatic void q_clear(input int ch);
    case (ch)
      0:       q_aw.delete();
      1:       q_w.delete();
      default: q_ar.delete();
    endcase
  endfunction

  function automatic logic [119:0] rnd_addr_cmd();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[119:0];
  endfunction

  function automatic logic [119:0] rnd_w_cmd();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return {47'd0, t[72:0]};
  endfunction

  // Transaction-level model state, advanced once per cycle by the monitor.
  // phase: 0 idle, 1 accepted but not yet on the bus, 2 presented on bus.
  int   phase   [3] = '{0, 0, 0};
  logic ack_exp [3] = '{1'b0, 1'b0, 1'b0};
  logic rev_exp  = 1'b0;
  logic last_rst = 1'b1;
  logic bp_exp   = 1'b0;
  logic rp_exp   = 1'b0;

  // Monitor: compare outputs, pop scoreboard entries, then advance the model.
  initial begin
    @(posedge clock);
    forever begin
      @(negedge clock);
      check("reset_ev", 128'(reset_ev), 128'(rev_exp));
      check("bready_rready", 128'({bus.bready, bus.rready}), 128'(2'b11));
      check("awlock_awqos", 128'({bus.awlock, bus.awqos}), 128'(0));
      for (int ch = 0; ch < 3; ch++) begin
        check({chn[ch], "_valid"}, 128'(bv[ch]), 128'(phase[ch] == 2));
        check({chn[ch], "_cmd_ready"}, 128'(cr[ch]), 128'(phase[ch] == 0));
        check({chn[ch], "_ack"}, 128'(ak[ch]), 128'(ack_exp[ch]));
        if (phase[ch] == 2) begin
          if (q_size(ch) == 0) begin
            n_vec++; n_err++;
            $display("FAIL %s_fields: bus valid with no expected command", chn[ch]);
          end else begin
            check({chn[ch], "_fields"}, 128'(bf[ch]), 128'(q_front(ch)));
          end
        end
      end
      check("bresp_valid", 128'(bresp_valid), 128'(bp_exp));
      if (bresp_valid) begin
        if (q_b.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL bresp: pulse with no expected beat");
        end else begin
          check("bresp", 128'({bresp_id, bresp_resp}), 128'(q_b.pop_front()));
        end
      end
      check("rresp_valid", 128'(rresp_valid), 128'(rp_exp));
      if (rresp_valid) begin
        if (q_r.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rresp: pulse with no expected beat");
        end else begin
          check("rresp", 128'({rresp_id, rresp_data, rresp_resp, rresp_last}),
                128'(q_r.pop_front()));
        end
      end

      // advance to what the next edge should produce
      rev_exp  = last_rst && !reset;
      last_rst = reset;
      bp_exp   = bus.bvalid && !reset;
      rp_exp   = bus.rvalid && !reset;
      for (int ch = 0; ch < 3; ch++) begin
        if (reset) begin
          phase[ch]   = 0;
          ack_exp[ch] = 1'b0;
          q_clear(ch);
        end else begin
          ack_exp[ch] = (phase[ch] == 2) && br[ch];
          if (phase[ch] == 0 && cv[ch]) begin
            phase[ch] = 1;
          end else if (phase[ch] == 1) begin
            phase[ch] = 2;
          end else if (phase[ch] == 2 && br[ch]) begin
            phase[ch] = 0;
            q_pop(ch);
          end
        end
      end
      if (reset) begin
        q_b.delete();
        q_r.delete();
      end
    end
  end

  // Slave ready generator.
  initial begin
    forever begin
      @(posedge clock); #1;
      awready_d = (rmode[0] == 1) ? 1'b1 : (rmode[0] == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      wready_d  = (rmode[1] == 1) ? 1'b1 : (rmode[1] == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      arready_d = (rmode[2] == 1) ? 1'b1 : (rmode[2] == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Present one command and hold it until the engine takes it.
  task automatic send(input int ch, input logic [119:0] v);
    bit accepted = 1'b0;
    @(posedge clock); #1;
    case (ch)
      0:       begin aw_cmd_vec = v;        aw_cmd_valid = 1'b1; end
      1:       begin w_cmd_vec  = v[72:0];  w_cmd_valid  = 1'b1; end
      default: begin ar_cmd_vec = v;        ar_cmd_valid = 1'b1; end
    endcase
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (cr[ch]) begin
        q_push(ch, v);
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) begin
      n_vec++; n_err++;
      $display("FAIL %s_cmd_accept: timed out waiting for cmd_ready", chn[ch]);
    end
    @(posedge clock); #1;
    // scramble the command inputs so the bus must come from staging
    case (ch)
      0:       begin aw_cmd_valid = 1'b0; aw_cmd_vec = rnd_addr_cmd(); end
      1:       begin w_cmd_valid  = 1'b0; w_cmd_vec  = rnd_addr_cmd()[72:0]; end
      default: begin ar_cmd_valid = 1'b0; ar_cmd_vec = rnd_addr_cmd(); end
    endcase
  endtask

  task automatic drain();
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (q_aw.size() == 0 && q_w.size() == 0 && q_ar.size() == 0 &&
          phase[0] == 0 && phase[1] == 0 && phase[2] == 0) return;
    end
    n_vec++; n_err++;
    $display("FAIL drain: outstanding requests never completed");
  endtask

  task automatic send_b(input logic [31:0] id, input logic [1:0] resp);
    @(posedge clock); #1;
    bvalid_d = 1'b1; bid_d = id; bresp_d = resp;
    q_b.push_back({id, resp});
    @(posedge clock); #1;
    bvalid_d = 1'b0;
  endtask

  task automatic send_r_burst(input logic [15:0] id, input int beats);
    @(posedge clock); #1;
    for (int k = 1; k <= beats; k++) begin
      rvalid_d = 1'b1; rid_d = id; rdata_d = 64'(k); rresp_d = 2'd0;
      rlast_d  = (k == beats);
      q_r.push_back({id, 64'(k), 2'd0, rlast_d});
      @(posedge clock); #1;
    end
    rvalid_d = 1'b0; rlast_d = 1'b0;
  endtask

  // Random write-response and read-data traffic.
  task automatic rand_resp(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock); #1;
      bvalid_d = ($urandom_range(0, 2) == 0);
      if (bvalid_d) begin
        bid_d = $urandom(); bresp_d = 2'($urandom_range(0, 3));
        q_b.push_back({bid_d, bresp_d});
      end
      rvalid_d = ($urandom_range(0, 1) == 0);
      if (rvalid_d) begin
        rid_d = 16'($urandom()); rdata_d = {$urandom(), $urandom()};
        rresp_d = 2'($urandom_range(0, 3)); rlast_d = 1'($urandom_range(0, 1));
        q_r.push_back({rid_d, rdata_d, rresp_d, rlast_d});
      end
    end
    @(posedge clock); #1;
    bvalid_d = 1'b0; rvalid_d = 1'b0;
  endtask

  task automatic rand_cmds(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clock);
      send(ch, (ch == 1) ? rnd_w_cmd() : rnd_addr_cmd());
    end
  endtask

  // Main sequence.
  initial begin
    // reset for 3 cycles then release
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    check("id_width", 128'(id_width), 128'(4));

    // AW with AWREADY tied high: VALID one cycle wide
    rmode[0] = 1;
    send(0, {64'h1000, 32'd3, 8'd0, 3'd3, 2'd1, 4'd0, 3'd0, 4'd0});
    drain();

    // AR with ARREADY held low for 5 cycles
    rmode[2] = 2;
    send(2, {64'h2000, 32'd7, 8'd0, 3'd3, 2'd1, 4'd3, 3'd2, 4'd1});
    repeat (5) @(posedge clock);
    rmode[2] = 1;
    drain();

    // W beat with delayed WREADY; a second beat must wait
    rmode[1] = 2;
    send(1, {47'd0, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1});
    fork
      send(1, {47'd0, 64'h0123_4567_89AB_CDEF, 8'h0F, 1'b0});
      begin
        repeat (2) @(posedge clock);
        rmode[1] = 1;
      end
    join
    drain();

    // write response then a 4-beat read burst
    send_b(32'd5, 2'd2);
    send_r_burst(16'h00A5, 4);
    repeat (3) @(posedge clock);

    // reset while AWVALID is waiting: request is discarded, no ack
    rmode[0] = 2;
    send(0, {64'h3000, 32'd9, 8'd1, 3'd2, 2'd1, 4'd0, 3'd0, 4'd0});
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    rmode[0] = 0;
    repeat (3) @(posedge clock);

    // randomized traffic on all channels
    rmode[0] = 0; rmode[1] = 0; rmode[2] = 0;
    fork
      rand_cmds(0, 60);
      rand_cmds(1, 60);
      rand_cmds(2, 60);
      rand_resp(300);
    join
    drain();
    repeat (4) @(posedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule

`default_nettype wire
